// File: rtl/nec_pkg.sv
// Shared types and helpers for the NEC frame checker.
package nec_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    PUBLISH = 2'd2,
    HOLD    = 2'd3
  } nec_state_e;

  // Bit offsets of the four byte fields inside a raw 32-bit frame.
  localparam int ADDR_LSB     = 0;
  localparam int ADDR_INV_LSB = 8;
  localparam int CMD_LSB      = 16;
  localparam int CMD_INV_LSB  = 24;

  // Field order mirrors the raw word: first member is the MSB byte.
  typedef struct packed {
    logic [7:0] cmd_inv;
    logic [7:0] cmd;
    logic [7:0] addr_inv;
    logic [7:0] addr;
  } nec_frame_t;

  // Nominal spacing of NEC repeat codes in CLOCK_50 cycles (108 ms).
  localparam int NEC_REPEAT_PERIOD = 5_400_000;

  // True when b is the bitwise complement of a.
  function automatic logic is_complement(input logic [7:0] a, input logic [7:0] b);
    return ((a ^ b) == 8'hFF);
  endfunction

  // Add a small increment to an 8-bit counter, sticking at 255.
  function automatic logic [7:0] sat_add(input logic [7:0] v, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, v} + {7'b0000000, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/nec_frame_checker_if.sv
// Decoder-to-checker link: raw frame plus the frame and repeat strobes.
interface nec_frame_checker_if;
  logic [31:0] frame_data;
  logic        frame_valid;
  logic        repeat_valid;

  modport master (output frame_data, output frame_valid, output repeat_valid);
  modport slave  (input  frame_data, input  frame_valid, input  repeat_valid);
endinterface

// File: rtl/nec_hold_timer.sv
// Key-hold timer: counts HOLD cycles and flags when the repeat window closes.
module nec_hold_timer #(
  parameter int REPEAT_TIMEOUT = 6_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int            W     = (REPEAT_TIMEOUT > 1) ? $clog2(REPEAT_TIMEOUT) : 1;
  localparam logic [W-1:0]  LIMIT = W'(REPEAT_TIMEOUT - 1);
  localparam logic [W-1:0]  ONE   = W'(1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise advance while enabled and stick at the limit.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LIMIT)) begin
      count_d = count_q + ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/nec_frame_checker.sv
// Validates NEC frames from the decoder, publishes address/command,
// tracks key-held status via repeat codes and counts rejected frames.
module nec_frame_checker
  import nec_pkg::*;
#(
  parameter int          CHECK_ADDR     = 1,
  parameter int          ADDR_FILTER_EN = 0,
  parameter logic [15:0] ADDR_MATCH     = 16'hFB04,
  parameter int          REPEAT_TIMEOUT = 6_000_000
) (
  input  logic               CLOCK_50,
  input  logic               RST_N,
  nec_frame_checker_if.slave fr,
  output logic [7:0]         cmd,
  output logic [15:0]        addr,
  output logic               cmd_valid,
  output logic               cmd_repeat,
  output logic               key_held,
  output logic               frame_err,
  output logic [7:0]         err_cnt,
  output logic [7:0]         LEDR
);

  nec_state_e  state_q;
  nec_frame_t  frame_q;
  logic        from_hold_q;
  logic [7:0]  cmd_q;
  logic [15:0] addr_q;
  logic [7:0]  ledr_q;
  logic        cmd_valid_q;
  logic        cmd_repeat_q;
  logic        key_held_q;
  logic        frame_err_q;
  logic [7:0]  err_cnt_q;

  logic [31:0] frame_raw_s;
  logic        frame_ok_s;
  logic        filtered_s;
  logic [15:0] pub_addr_s;
  logic [1:0]  err_inc_s;
  logic        tmr_clear_s;
  logic        tmr_enable_s;
  logic        tmr_expired_s;

  assign frame_raw_s = frame_q;

  // Complement checks on the captured frame; the address pair is optional.
  always_comb begin
    frame_ok_s = is_complement(frame_q.cmd, frame_q.cmd_inv);
    if (CHECK_ADDR != 0) begin
      frame_ok_s = frame_ok_s && is_complement(frame_q.addr, frame_q.addr_inv);
    end else begin
      frame_ok_s = frame_ok_s;
    end
  end

  // Published address: 8-bit address zero-extended, or the full 16-bit extended one.
  always_comb begin
    if (CHECK_ADDR != 0) begin
      pub_addr_s = {8'h00, frame_q.addr};
    end else begin
      pub_addr_s = frame_raw_s[ADDR_LSB +: 16];
    end
  end

  assign filtered_s = (ADDR_FILTER_EN != 0) && (frame_raw_s[ADDR_LSB +: 16] != ADDR_MATCH);

  // Error increments: a rejected frame in CHECK, plus any frame arriving while busy.
  always_comb begin
    err_inc_s = 2'd0;
    if (state_q == CHECK) begin
      err_inc_s = {1'b0, ~frame_ok_s} + {1'b0, fr.frame_valid};
    end else if (state_q == PUBLISH) begin
      err_inc_s = {1'b0, fr.frame_valid};
    end else begin
      err_inc_s = 2'd0;
    end
  end

  // Timer reloads on publish and on an accepted repeat; it only runs in an undisturbed HOLD.
  assign tmr_clear_s  = (state_q == PUBLISH) ||
                        ((state_q == HOLD) && fr.repeat_valid && !fr.frame_valid);
  assign tmr_enable_s = (state_q == HOLD) && !fr.frame_valid && !fr.repeat_valid;

  nec_hold_timer #(
    .REPEAT_TIMEOUT (REPEAT_TIMEOUT)
  ) u_hold_timer (
    .clk_i     (CLOCK_50),
    .rst_ni    (RST_N),
    .clear_i   (tmr_clear_s),
    .enable_i  (tmr_enable_s),
    .expired_o (tmr_expired_s)
  );

  // Main FSM with all outputs registered; strobes default low every cycle.
  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      frame_q      <= '0;
      from_hold_q  <= 1'b0;
      cmd_q        <= 8'h00;
      addr_q       <= 16'h0000;
      ledr_q       <= 8'h00;
      cmd_valid_q  <= 1'b0;
      cmd_repeat_q <= 1'b0;
      key_held_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      err_cnt_q    <= 8'h00;
    end else begin
      cmd_valid_q  <= 1'b0;
      cmd_repeat_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_cnt_q    <= sat_add(err_cnt_q, err_inc_s);
      case (state_q)
        IDLE: begin
          if (fr.frame_valid) begin
            frame_q     <= nec_frame_t'(fr.frame_data);
            from_hold_q <= 1'b0;
            state_q     <= CHECK;
          end else begin
            state_q <= IDLE;
          end
        end
        CHECK: begin
          if (!frame_ok_s) begin
            frame_err_q <= 1'b1;
            state_q     <= from_hold_q ? HOLD : IDLE;
          end else if (filtered_s) begin
            state_q <= from_hold_q ? HOLD : IDLE;
          end else begin
            cmd_valid_q <= 1'b1;
            cmd_q       <= frame_q.cmd;
            addr_q      <= pub_addr_s;
            ledr_q      <= frame_q.cmd;
            key_held_q  <= 1'b1;
            state_q     <= PUBLISH;
          end
        end
        PUBLISH: begin
          state_q <= HOLD;
        end
        HOLD: begin
          if (fr.frame_valid) begin
            frame_q     <= nec_frame_t'(fr.frame_data);
            from_hold_q <= 1'b1;
            state_q     <= CHECK;
          end else if (fr.repeat_valid) begin
            cmd_valid_q  <= 1'b1;
            cmd_repeat_q <= 1'b1;
            state_q      <= HOLD;
          end else if (tmr_expired_s) begin
            key_held_q <= 1'b0;
            state_q    <= IDLE;
          end else begin
            state_q <= HOLD;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd        = cmd_q;
  assign addr       = addr_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_repeat = cmd_repeat_q;
  assign key_held   = key_held_q;
  assign frame_err  = frame_err_q;
  assign err_cnt    = err_cnt_q;
  assign LEDR       = ledr_q;

endmodule

// File: tb/tb_nec_frame_checker.sv
// Bench for nec_frame_checker: two instances (standard NEC with address check,
// extended NEC with address filter) share one stimulus stream.
module tb_nec_frame_checker;
  import nec_pkg::*;

  localparam int TO = 40;              // scaled-down repeat timeout
  localparam int RP = TO * 108 / 120;  // scaled repeat spacing (108 ms vs 120 ms)

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fv, rv;
  logic [31:0] fdata;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  nec_frame_checker_if ifa ();
  nec_frame_checker_if ifb ();
  assign ifa.frame_data = fdata;  assign ifa.frame_valid = fv;  assign ifa.repeat_valid = rv;
  assign ifb.frame_data = fdata;  assign ifb.frame_valid = fv;  assign ifb.repeat_valid = rv;

  logic [7:0] a_cmd, a_err, a_led, b_cmd, b_err, b_led;
  logic [15:0] a_addr, b_addr;
  logic a_cv, a_cr, a_kh, a_fe, b_cv, b_cr, b_kh, b_fe;

  nec_frame_checker #(.CHECK_ADDR(1), .ADDR_FILTER_EN(0), .ADDR_MATCH(16'hFB04), .REPEAT_TIMEOUT(TO)) dut_a (
    .CLOCK_50(clk), .RST_N(rst_n), .fr(ifa), .cmd(a_cmd), .addr(a_addr), .cmd_valid(a_cv),
    .cmd_repeat(a_cr), .key_held(a_kh), .frame_err(a_fe), .err_cnt(a_err), .LEDR(a_led));

  nec_frame_checker #(.CHECK_ADDR(0), .ADDR_FILTER_EN(1), .ADDR_MATCH(16'h1234), .REPEAT_TIMEOUT(TO)) dut_b (
    .CLOCK_50(clk), .RST_N(rst_n), .fr(ifb), .cmd(b_cmd), .addr(b_addr), .cmd_valid(b_cv),
    .cmd_repeat(b_cr), .key_held(b_kh), .frame_err(b_fe), .err_cnt(b_err), .LEDR(b_led));

  // Reference model, index 0 = standard NEC instance, 1 = extended + filtered instance.
  logic [7:0]  m_cmd[2], m_led[2], m_err[2];
  logic [15:0] m_addr[2];
  logic [31:0] m_frame[2];
  bit          m_cv[2], m_cr[2], m_fe[2], m_held[2], m_chk_pend[2], m_pub_pend[2];
  int          m_deadline[2];   // clock edge at which the held key is released

  task automatic model_sat_err(input int i, input int inc);
    int s;
    s = int'(m_err[i]) + inc;
    m_err[i] = (s > 255) ? 8'd255 : 8'(s);
  endtask

  task automatic model_edge(input int i);
    logic [31:0] f;
    int drops;
    bit ok;
    m_cv[i] = 1'b0; m_cr[i] = 1'b0; m_fe[i] = 1'b0;
    if (rst_n === 1'b0) begin
      m_cmd[i] = 8'h00; m_addr[i] = 16'h0000; m_led[i] = 8'h00; m_err[i] = 8'h00;
      m_held[i] = 1'b0; m_chk_pend[i] = 1'b0; m_pub_pend[i] = 1'b0; m_deadline[i] = 0;
    end else if (m_chk_pend[i]) begin
      f = m_frame[i];
      m_chk_pend[i] = 1'b0;
      drops = (fv === 1'b1) ? 1 : 0;
      // A byte and its complement always sum to exactly 255.
      ok = (int'(f[31:24]) + int'(f[23:16]) == 255) &&
           ((i != 0) || (int'(f[15:8]) + int'(f[7:0]) == 255));
      if (!ok) begin
        m_fe[i] = 1'b1; drops++;
        m_deadline[i] += 2;           // two edges spent outside HOLD do not age the key
      end else if ((i == 1) && (f[15:0] != 16'h1234)) begin
        m_deadline[i] += 2;
      end else begin
        m_cv[i] = 1'b1; m_cmd[i] = f[23:16]; m_led[i] = f[23:16];
        m_addr[i] = (i == 0) ? {8'h00, f[7:0]} : f[15:0];
        m_held[i] = 1'b1; m_pub_pend[i] = 1'b1;
      end
      model_sat_err(i, drops);
    end else if (m_pub_pend[i]) begin
      m_pub_pend[i] = 1'b0;
      m_deadline[i] = cyc + TO;
      if (fv === 1'b1) model_sat_err(i, 1);
    end else if (fv === 1'b1) begin
      m_frame[i] = fdata; m_chk_pend[i] = 1'b1;
    end else if (m_held[i] && (rv === 1'b1)) begin
      m_cv[i] = 1'b1; m_cr[i] = 1'b1; m_deadline[i] = cyc + TO;
    end else if (m_held[i] && (cyc >= m_deadline[i])) begin
      m_held[i] = 1'b0;
    end
  endtask

  // One clock: model follows the active edge, outputs are read at the falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    fv = 1'b0; rv = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fv = 1'b1; fdata = 32'hF708FB04;   // reset must win over the strobe
    tick();
    n_tests++; if ({a_cmd, a_addr, a_cv, a_cr, a_kh, a_fe, a_err, a_led} !== 43'h0) begin n_fail++; $display("FAIL reset_a got %h want 0", {a_cmd, a_addr, a_cv, a_cr, a_kh, a_fe, a_err, a_led}); end
    n_tests++; if ({b_cmd, b_addr, b_cv, b_cr, b_kh, b_fe, b_err, b_led} !== 43'h0) begin n_fail++; $display("FAIL reset_b got %h want 0", {b_cmd, b_addr, b_cv, b_cr, b_kh, b_fe, b_err, b_led}); end
    rst_n = 1'b1;
    tick();
    n_tests++; if (a_cv !== 1'b0) begin n_fail++; $display("FAIL reset_strobe_dropped cmd_valid got %b want 0", a_cv); end
  endtask

  task automatic test_valid_frame();
    fdata = 32'hF708FB04; fv = 1'b1;
    tick();
    n_tests++; if (a_cv !== 1'b0) begin n_fail++; $display("FAIL valid_n1 cmd_valid got %b want 0", a_cv); end
    tick();
    n_tests++; if (a_cv !== 1'b1 || a_cr !== 1'b0) begin n_fail++; $display("FAIL valid_strobe cv/cr got %b%b want 10", a_cv, a_cr); end
    n_tests++; if (a_cmd !== 8'h08 || a_addr !== 16'h0004) begin n_fail++; $display("FAIL valid_fields cmd/addr got %h/%h want 08/0004", a_cmd, a_addr); end
    n_tests++; if (a_led !== 8'h08 || a_kh !== 1'b1) begin n_fail++; $display("FAIL valid_led_held got %h/%b want 08/1", a_led, a_kh); end
    n_tests++; if (b_cv !== 1'b0 || b_fe !== 1'b0 || b_err !== 8'h00) begin n_fail++; $display("FAIL filter_silent got cv %b fe %b err %0d want 0 0 0", b_cv, b_fe, b_err); end
    tick();
    n_tests++; if (a_cv !== 1'b0 || a_kh !== 1'b1) begin n_fail++; $display("FAIL valid_after cv/kh got %b%b want 01", a_cv, a_kh); end
  endtask

  task automatic test_repeats();
    for (int k = 0; k < 3; k++) begin
      for (int j = 1; j < RP; j++) begin
        tick();
        n_tests++; if (a_kh !== 1'b1 || a_cv !== 1'b0) begin n_fail++; $display("FAIL repeat_gap%0d kh/cv got %b%b want 10", k, a_kh, a_cv); end
      end
      rv = 1'b1;
      tick();
      n_tests++; if (a_cv !== 1'b1 || a_cr !== 1'b1 || a_cmd !== 8'h08 || a_kh !== 1'b1) begin
        n_fail++; $display("FAIL repeat%0d cv/cr/cmd/kh got %b%b/%h/%b want 11/08/1", k, a_cv, a_cr, a_cmd, a_kh);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    while (n < 3 * TO) begin
      tick();
      n++;
      if (a_kh !== 1'b1) break;
    end
    n_tests++; if (n !== TO || a_kh !== 1'b0) begin n_fail++; $display("FAIL timeout_len got %0d cycles kh %b want %0d cycles kh 0", n, a_kh, TO); end
    n_tests++; if (a_led !== 8'h08 || a_cmd !== 8'h08) begin n_fail++; $display("FAIL timeout_keep led/cmd got %h/%h want 08/08", a_led, a_cmd); end
    rv = 1'b1;
    tick();
    tick();
    n_tests++; if (a_cv !== 1'b0 || a_kh !== 1'b0) begin n_fail++; $display("FAIL late_repeat cv/kh got %b%b want 00", a_cv, a_kh); end
  endtask

  task automatic test_corrupt();
    fdata = 32'hF608FB04; fv = 1'b1;
    tick();
    n_tests++; if (a_fe !== 1'b0) begin n_fail++; $display("FAIL corrupt_n1 frame_err got %b want 0", a_fe); end
    tick();
    n_tests++; if (a_fe !== 1'b1 || a_err !== 8'd1 || a_cv !== 1'b0) begin n_fail++; $display("FAIL corrupt fe/err/cv got %b/%0d/%b want 1/1/0", a_fe, a_err, a_cv); end
    n_tests++; if (a_led !== 8'h08) begin n_fail++; $display("FAIL corrupt_led got %h want 08", a_led); end
    n_tests++; if (b_fe !== 1'b1 || b_err !== 8'd1) begin n_fail++; $display("FAIL corrupt_b fe/err got %b/%0d want 1/1", b_fe, b_err); end
    tick();
    n_tests++; if (a_fe !== 1'b0) begin n_fail++; $display("FAIL corrupt_pulse frame_err got %b want 0", a_fe); end
  endtask

  task automatic test_extended();
    fdata = 32'hF7081234; fv = 1'b1;
    tick();
    tick();
    n_tests++; if (b_cv !== 1'b1 || b_addr !== 16'h1234 || b_cmd !== 8'h08) begin n_fail++; $display("FAIL ext_publish cv/addr/cmd got %b/%h/%h want 1/1234/08", b_cv, b_addr, b_cmd); end
    n_tests++; if (a_fe !== 1'b1 || a_err !== 8'd2) begin n_fail++; $display("FAIL ext_on_std fe/err got %b/%0d want 1/2", a_fe, a_err); end
    tick();
    fdata = 32'hF7081235; fv = 1'b1;
    tick();
    tick();
    n_tests++; if (b_cv !== 1'b0 || b_fe !== 1'b0 || b_kh !== 1'b1 || b_err !== 8'd1) begin
      n_fail++; $display("FAIL ext_filtered cv/fe/kh/err got %b/%b/%b/%0d want 0/0/1/1", b_cv, b_fe, b_kh, b_err);
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 260; k++) begin
      fdata = 32'hF608FB04; fv = 1'b1;
      tick();
      tick();
    end
    n_tests++; if (a_err !== 8'd255) begin n_fail++; $display("FAIL sat_a err_cnt got %0d want 255", a_err); end
    n_tests++; if (b_err !== 8'd255) begin n_fail++; $display("FAIL sat_b err_cnt got %0d want 255", b_err); end
  endtask

  task automatic test_reset_mid_hold();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    fdata = 32'hF708FB04; fv = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    n_tests++; if (a_kh !== 1'b1) begin n_fail++; $display("FAIL pre_reset key_held got %b want 1", a_kh); end
    rst_n = 1'b0;
    tick();
    n_tests++; if ({a_cmd, a_addr, a_cv, a_cr, a_kh, a_fe, a_err, a_led} !== 43'h0) begin n_fail++; $display("FAIL reset_mid_hold got %h want 0", {a_cmd, a_addr, a_cv, a_cr, a_kh, a_fe, a_err, a_led}); end
    rst_n = 1'b1; rv = 1'b1;
    tick();
    tick();
    n_tests++; if (a_cv !== 1'b0 || a_kh !== 1'b0) begin n_fail++; $display("FAIL repeat_after_reset cv/kh got %b%b want 00", a_cv, a_kh); end
  endtask

  task automatic test_random();
    logic [7:0] a8, c8;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      a8 = 8'($urandom_range(0, 255));
      c8 = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0:       fdata = {~c8, c8, ~a8, a8};
        1:       fdata = {~c8, c8, 16'h1234};
        2:       fdata = {~c8, c8, 16'hFB04};
        default: fdata = $urandom();
      endcase
      fv = ($urandom_range(0, 5) == 0);
      rv = ($urandom_range(0, 7) == 0);
      tick();
      n_tests++;
      if ({a_cmd, a_addr, a_cv, a_cr, a_kh, a_fe, a_err, a_led} !== {m_cmd[0], m_addr[0], m_cv[0], m_cr[0], m_held[0], m_fe[0], m_err[0], m_led[0]}) begin
        n_fail++; $display("FAIL rand_a cycle %0d got %h want %h", cyc, {a_cmd, a_addr, a_cv, a_cr, a_kh, a_fe, a_err, a_led},
                           {m_cmd[0], m_addr[0], m_cv[0], m_cr[0], m_held[0], m_fe[0], m_err[0], m_led[0]});
      end
      n_tests++;
      if ({b_cmd, b_addr, b_cv, b_cr, b_kh, b_fe, b_err, b_led} !== {m_cmd[1], m_addr[1], m_cv[1], m_cr[1], m_held[1], m_fe[1], m_err[1], m_led[1]}) begin
        n_fail++; $display("FAIL rand_b cycle %0d got %h want %h", cyc, {b_cmd, b_addr, b_cv, b_cr, b_kh, b_fe, b_err, b_led},
                           {m_cmd[1], m_addr[1], m_cv[1], m_cr[1], m_held[1], m_fe[1], m_err[1], m_led[1]});
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; fv = 1'b0; rv = 1'b0; fdata = 32'h0;
    @(negedge clk);
    test_reset();
    test_valid_frame();
    test_repeats();
    test_timeout();
    test_corrupt();
    test_extended();
    test_saturation();
    test_reset_mid_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
